// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding and the
// arbiter sequencer state set.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: first valid request at or
// above ptr, wrapping around.
module rr_picker #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // scan from ptr with wrap, keep the first hit
  always_comb begin
    logic [IW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = IW'((int'(ptr) + k) % N_REQ);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters; one op
// in flight, round-robin order, watchdog on results.
import alu_pkg::*;

module alu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*OP_W-1:0]  req_op,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   alu_inputs_valid,
  output logic [OP_W-1:0]        alu_op_code,
  output logic [DATA_W-1:0]      alu_input_a,
  output logic [DATA_W-1:0]      alu_input_b,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic                   alu_result_valid,
  output logic                   busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t        state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     owner;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic [CW-1:0]     cnt;

  logic [N_REQ-1:0]  pick_grant;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [N_REQ-1:0]  owner_oh;

  logic [OP_W-1:0]   op_arr [N_REQ];
  logic [DATA_W-1:0] a_arr  [N_REQ];
  logic [DATA_W-1:0] b_arr  [N_REQ];

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // unpack the flat request buses per requester
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      op_arr[i] = req_op[i*OP_W +: OP_W];
      a_arr[i]  = req_a[i*DATA_W +: DATA_W];
      b_arr[i]  = req_b[i*DATA_W +: DATA_W];
    end
  end

  // sequencer: accept, issue, wait/watchdog, respond
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            owner <= pick_idx;
            op_q  <= op_arr[pick_idx];
            a_q   <= a_arr[pick_idx];
            b_q   <= b_arr[pick_idx];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (alu_result_valid) begin
            data_q <= alu_result;
            err_q  <= 1'b0;
            state  <= RESP;
          end else if (cnt == CW'(TIMEOUT)) begin
            data_q <= '0;
            err_q  <= 1'b1;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rr_ptr <= (owner == IW'(N_REQ - 1))
                    ? '0 : owner + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // one-hot owner for the response strobe
  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  assign req_ready = (state == IDLE && reset_n)
                   ? pick_grant : '0;

  assign alu_inputs_valid = (state == ISSUE);
  assign alu_op_code      = op_q;
  assign alu_input_a      = a_q;
  assign alu_input_b      = b_q;

  assign rsp_valid = (state == RESP) ? owner_oh : '0;
  assign rsp_data  = (state == RESP) ? data_q : '0;
  assign rsp_err   = (state == RESP) && err_q;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a
// behavioural ALU and a response monitor.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*OW-1:0] req_op;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            alu_inputs_valid;
  logic [OW-1:0]   alu_op_code;
  logic [DW-1:0]   alu_input_a;
  logic [DW-1:0]   alu_input_b;
  logic [DW-1:0]   alu_result;
  logic            alu_result_valid;
  logic            busy;

  typedef struct packed {
    logic [1:0]    own;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   alu_suppress = 1'b0;
  int   alu_delay    = 0;
  int   stray_cnt    = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .N_REQ   (N),
    .DATA_W  (DW),
    .OP_W    (OW),
    .TIMEOUT (TO)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_a            (req_a),
    .req_b            (req_b),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err),
    .alu_inputs_valid (alu_inputs_valid),
    .alu_op_code      (alu_op_code),
    .alu_input_a      (alu_input_a),
    .alu_input_b      (alu_input_b),
    .alu_result       (alu_result),
    .alu_result_valid (alu_result_valid),
    .busy             (busy)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push(input int own,
                      input logic [DW-1:0] d,
                      input logic err);
    exp_t e;
    e.own  = 2'(own);
    e.data = d;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i,
                         input logic [OW-1:0] op,
                         input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    req_op[i*OW +: OW] = op;
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
    req_valid[i]       = 1'b1;
  endtask

  task automatic wait_grant(input int i,
                            output int waited);
    waited = -1;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (req_ready[i]) begin
        waited = n;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 30; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #3;
    end
    chk(name, sb.size(), 0);
  endtask

  task automatic run_one(input string name,
                         input int i,
                         input logic [OW-1:0] op,
                         input logic [DW-1:0] a,
                         input logic [DW-1:0] b,
                         input logic [DW-1:0] d,
                         input logic err,
                         input int lat_exp);
    int w;
    int lat;
    push(i, d, err);
    @(negedge clk);
    set_req(i, op, a, b);
    wait_grant(i, w);
    chk({name, "_grant"}, w >= 0, 1);
    @(negedge clk);
    req_valid[i] = 1'b0;
    lat = 1;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (rsp_valid[i]) break;
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, lat_exp);
    drain({name, "_drain"});
  endtask

  // behavioural ALU: result one cycle after issue
  initial begin : alu_model
    logic [DW-1:0] r;
    int seen;
    seen = 0;
    alu_result_valid = 1'b0;
    alu_result = '0;
    forever begin
      @(negedge clk);
      #2;
      if (alu_inputs_valid && !alu_suppress) begin
        case (alu_op_t'(alu_op_code))
          ALU_ADD: r = alu_input_a + alu_input_b;
          ALU_SUB: r = alu_input_a - alu_input_b;
          ALU_AND: r = alu_input_a & alu_input_b;
          ALU_OR:  r = alu_input_a | alu_input_b;
          ALU_XOR: r = alu_input_a ^ alu_input_b;
          default: r = '0;
        endcase
        @(posedge clk);
        repeat (alu_delay) @(posedge clk);
        #1;
        alu_result_valid = 1'b1;
        alu_result = r;
        @(posedge clk);
        #1;
        alu_result_valid = 1'b0;
        alu_result = '0;
      end else if (stray_cnt != seen) begin
        seen = stray_cnt;
        #1;
        alu_result_valid = 1'b1;
        alu_result = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        alu_result_valid = 1'b0;
        alu_result = '0;
      end
    end
  end

  // response monitor: pop and compare on handshake
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid != '0)
        chk("rsp_onehot", $onehot(rsp_valid), 1);
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: req %0d data %0h expected none",
                     i, rsp_data);
          end else begin
            e = sb.pop_front();
            chk("rsp_owner", i, e.own);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", rsp_err, e.err);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int w;
    int g_idx [5];
    int g_cyc [5];
    int ng;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};

    reset_n   = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;

    // reset state, including gated req_ready
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_valid", alu_inputs_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // single request with exact cycle timing
    push(0, 32'd12, 1'b0);
    @(negedge clk);
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    #1;
    chk("t1_ready_c0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t1_issue_c1", alu_inputs_valid, 1);
    chk("t1_op", alu_op_code, ALU_ADD);
    chk("t1_a", alu_input_a, 5);
    chk("t1_b", alu_input_b, 7);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    #1;
    chk("t1_issue_c2", alu_inputs_valid, 0);
    chk("t1_rsp_c2", rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("t1_rsp_c3", rsp_valid, 4'b0001);
    drain("t1_drain");

    // fresh pointer, all four compete
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    push(0, 32'd9, 1'b0);
    push(1, 32'd10, 1'b0);
    push(2, 32'd11, 1'b0);
    push(3, 32'd12, 1'b0);
    push(0, 32'd9, 1'b0);
    @(negedge clk);
    for (int i = 0; i < N; i++)
      set_req(i, ALU_SUB, 32'(i + 10), 32'd1);
    ng = 0;
    for (int n = 0; n < 80; n++) begin
      #1;
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++)
          if (req_ready[i]) g_idx[ng] = i;
        g_cyc[ng] = n;
        ng++;
      end
      @(negedge clk);
      if (ng == 5) break;
    end
    req_valid = '0;
    chk("rr_count", ng, 5);
    for (int k = 0; k < 5; k++) begin
      if (k < ng) begin
        chk("rr_order", g_idx[k], exp_order[k]);
        if (k > 0)
          chk("rr_spacing", g_cyc[k] - g_cyc[k-1], 4);
      end
    end
    drain("rr_drain");

    // backpressure on requester 2
    rsp_ready = 4'b1011;
    push(2, 32'd123, 1'b0);
    push(0, 32'd2, 1'b0);
    @(negedge clk);
    set_req(2, ALU_ADD, 32'd100, 32'd23);
    wait_grant(2, w);
    chk("bp_grant", w >= 0, 1);
    @(negedge clk);
    req_valid[2] = 1'b0;
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    for (int n = 0; n < 20; n++) begin
      #1;
      if (rsp_valid[2]) break;
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      chk("bp_rsp_valid", rsp_valid, 4'b0100);
      chk("bp_rsp_data", rsp_data, 123);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_alu_valid", alu_inputs_valid, 0);
      @(negedge clk);
      #1;
    end
    rsp_ready = '1;
    wait_grant(0, w);
    chk("bp_next_grant", w >= 0, 1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    drain("bp_drain");

    // watchdog: no result, then result on last cycle
    alu_suppress = 1'b1;
    run_one("to_err", 1, ALU_ADD, 32'd3, 32'd4,
            32'd0, 1'b1, TO + 3);
    alu_suppress = 1'b0;
    alu_delay = TO;
    run_one("to_edge", 1, ALU_ADD, 32'd3, 32'd4,
            32'd7, 1'b0, TO + 3);
    alu_delay = 0;

    // reset in WAIT aborts the op
    alu_suppress = 1'b1;
    @(negedge clk);
    set_req(2, ALU_ADD, 32'd9, 32'd9);
    wait_grant(2, w);
    chk("rm_grant", w >= 0, 1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    set_req(3, ALU_ADD, 32'h10, 32'h20);
    set_req(1, ALU_SUB, 32'd50, 32'd8);
    #1;
    chk("rm_busy_pre", busy, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_alu_valid", alu_inputs_valid, 0);
    chk("rm_rsp_valid", rsp_valid, 0);
    chk("rm_req_ready", req_ready, 0);
    chk("rm_rsp_data", rsp_data, 0);
    chk("rm_alu_a", alu_input_a, 0);
    alu_suppress = 1'b0;
    push(1, 32'd42, 1'b0);
    push(3, 32'h30, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rm_ptr0_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_grant(3, w);
    chk("rm_grant3", w >= 0, 1);
    @(negedge clk);
    req_valid = '0;
    drain("rm_drain");

    // stray ALU strobe while idle
    @(negedge clk);
    stray_cnt++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("stray_busy", busy, 0);
      chk("stray_rsp", rsp_valid, 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter and sequencer that shares one ALU instance between N_REQ requesters. Each requester submits an (op_code, A, B) operation over a valid/ready handshake. The block issues one operation at a time to the ALU and returns the result to the owning requester over a valid/ready response channel. A WAIT-state watchdog converts a missing ALU result into an error response.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width
OP_W, 4, op_code width (matches shared alu op enum)
TIMEOUT, 15, max cycles in WAIT before error response (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester operation valid
req_ready  out  N_REQ  per-requester accept (one-hot or zero)
req_op  in  N_REQ*OP_W  packed op codes, slice i = requester i
req_a  in  N_REQ*DATA_W  packed operand A
req_b  in  N_REQ*DATA_W  packed operand B
rsp_valid  out  N_REQ  per-requester response valid (one-hot or zero)
rsp_ready  in  N_REQ  per-requester response accept
rsp_data  out  DATA_W  result, shared across requesters, qualified by rsp_valid
rsp_err  out  1  timeout flag, qualified by rsp_valid
alu_inputs_valid  out  1  single-cycle issue strobe to ALU
alu_op_code  out  OP_W  op to ALU
alu_input_a  out  DATA_W  operand A to ALU
alu_input_b  out  DATA_W  operand B to ALU
alu_result  in  DATA_W  ALU result
alu_result_valid  in  1  ALU single-cycle result strobe
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low. On assertion all state clears immediately.
- Reset values: state=IDLE; rr pointer=0; all outputs 0.
- ALU contract: result_valid pulses exactly one cycle after an issue cycle. Back-to-back issue strobes are illegal; this block guarantees at most one in flight and a minimum spacing of 4 cycles.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Pick the first i with req_valid[i]=1, scanning from the rr pointer upward with wrap.
  - req_ready[i]=1 combinationally in that cycle only. Latch op/a/b and owner id.
  - Go to ISSUE. If no request is valid, stay in IDLE.
- ISSUE:
  - alu_inputs_valid=1 for exactly this cycle; alu_op_code/a/b driven from the latched registers.
  - Clear the watchdog counter. Go to WAIT.
- WAIT:
  - On alu_result_valid, capture alu_result, set err=0, go to RESP.
  - Otherwise increment the counter. When counter==TIMEOUT, set data=0, err=1, go to RESP.
  - If result_valid arrives in the same cycle the counter hits TIMEOUT, the result wins (err=0).
- RESP:
  - rsp_valid[owner]=1; rsp_data and rsp_err stay stable until rsp_ready[owner]=1.
  - On the handshake, go to IDLE and set rr pointer=(owner+1) mod N_REQ.
  - rsp_ready of non-owners is ignored.
- Latency: request accepted in cycle 0 (IDLE) -> issue cycle 1 -> result cycle 2 -> rsp_valid cycle 3. Minimum 4 cycles per operation.
- Stray alu_result_valid outside WAIT is ignored.
- A requester dropping req_valid before req_ready is allowed and is not latched.
- alu_* outputs and rsp_* are decoded from registered state. The only combinational path is req_valid -> req_ready.
- The pointer advances only on response completion, never on timeout-free abandonment.
- Reset mid-operation aborts the operation with no response; the ALU strobe drops asynchronously.

Decomposition:
- Shared package alu_pkg: existing alu op enum plus the new arb_state_t enum (IDLE/ISSUE/WAIT/RESP).
- Sub-module rr_picker: combinational; inputs req vector and pointer; outputs one-hot grant, index and any-valid.

Test Plan:
- Single request: req0 ADD A=5 B=7 -> req_ready[0] in cycle 0, alu_inputs_valid in cycle 1, rsp_valid[0] with data=12 and err=0 in cycle 3.
- All four requesters hold SUBTRACT A=i+10 B=1 continuously -> grants in order 0,1,2,3,0, each 4 cycles apart; each response data=i+9 goes only to its owner.
- Backpressure: rsp_ready[2] held low for 10 cycles -> rsp_valid[2] and data stable throughout; no new req_ready during that time; alu_inputs_valid stays 0.
- Timeout: ALU model suppresses result_valid -> rsp_valid after TIMEOUT+1 WAIT cycles with err=1 and data=0. A result arriving exactly on the TIMEOUT cycle yields err=0 with the real data.
- Reset mid-op: deassert reset_n during WAIT -> all outputs 0 without a clock edge. After release, a req from requester 3 is granted with pointer=0 scan order, and no stale response appears.
- Stray ALU result_valid pulse while IDLE -> no rsp_valid and no state change.
